// File: rtl/mdu_seq.sv
// rtl/mdu_seq.sv - iterative RV64 multiply/divide sequencer sharing the execute-stage ALU
//
// Purpose: accepts one MUL/DIV/DIVU/REM/REMU request at a time. It runs 64
// shift-add (MUL) or restoring-divide (DIV family) iterations on the shared
// ALU, then returns the result through a valid/ready handshake.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   in_valid/in_ready      request handshake (in_ready only in IDLE)
//   func, src1, src2       funct3 and operands
//   out_valid/out_ready    result handshake
//   result                 registered result, held while out_valid
//   busy                   block owns the ALU (CALC and FIX)
//   alu_op1/op2/op_type/add/shamt/shtype  ALU request (zero outside CALC)
//   alu_rst, alu_lt        ALU sum/difference and unsigned op1<op2
module mdu_seq #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        func,
    input  logic [XLEN-1:0]   src1,
    input  logic [XLEN-1:0]   src2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   result,
    output logic              busy,
    output logic [XLEN-1:0]   alu_op1,
    output logic [XLEN-1:0]   alu_op2,
    output logic [2:0]        alu_op_type,
    output logic              alu_add,
    output logic [5:0]        alu_shamt,
    output logic              alu_shtype,
    input  logic [XLEN-1:0]   alu_rst,
    input  logic              alu_lt
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [XLEN-1:0]   result_q;
    // acc_q: MUL accumulator or partial remainder.
    // mcand_q: shifting multiplicand or fixed divisor.
    // mplier_q: shifting multiplier or dividend, which becomes the quotient.
    logic [XLEN-1:0]   acc_q, mcand_q, mplier_q;
    logic              is_div_q, is_rem_q, is_signed_q, sign_q_q, sign_r_q;

    logic              req_div, req_rem, req_signed;
    logic              div_by_zero, div_ovf;
    logic [XLEN-1:0]   abs1, abs2;
    logic              qbit_d;
    logic [XLEN-1:0]   rem_d, fix_d;

    assign req_div    = func[2];
    assign req_rem    = func[1];
    assign req_signed = req_div & ~func[0];

    assign abs1 = (req_signed && src1[XLEN-1]) ? -src1 : src1;
    assign abs2 = (req_signed && src2[XLEN-1]) ? -src2 : src2;

    assign div_by_zero = req_div && (src2 == '0);
    assign div_ovf     = req_signed && (src1 == INT_MIN) && (src2 == '1);

    // The shifted remainder is 65 bits wide but the ALU only sees the low 64.
    // When the dropped top bit is set, the shifted value exceeds any divisor,
    // so the subtraction always succeeds and its low 64 bits are exact.
    assign qbit_d = acc_q[XLEN-1] | ~alu_lt;
    assign rem_d  = qbit_d ? alu_rst : alu_op1;

    always_comb begin
        fix_d = acc_q;
        if (is_div_q) begin
            if (is_rem_q)
                fix_d = (is_signed_q && sign_r_q) ? -acc_q : acc_q;
            else
                fix_d = (is_signed_q && sign_q_q) ? -mplier_q : mplier_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            result_q    <= '0;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            is_div_q    <= 1'b0;
            is_rem_q    <= 1'b0;
            is_signed_q <= 1'b0;
            sign_q_q    <= 1'b0;
            sign_r_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        is_div_q    <= req_div;
                        is_rem_q    <= req_rem;
                        is_signed_q <= req_signed;
                        sign_q_q    <= src1[XLEN-1] ^ src2[XLEN-1];
                        sign_r_q    <= src1[XLEN-1];
                        acc_q       <= '0;
                        mcand_q     <= abs2;
                        mplier_q    <= abs1;
                        cnt_q       <= '0;
                        if (div_by_zero) begin
                            result_q <= req_rem ? src1 : '1;
                            state_q  <= S_DONE;
                        end else if (div_ovf) begin
                            result_q <= req_rem ? '0 : INT_MIN;
                            state_q  <= S_DONE;
                        end else begin
                            state_q  <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (is_div_q) begin
                        acc_q    <= rem_d;
                        mplier_q <= {mplier_q[XLEN-2:0], qbit_d};
                    end else begin
                        if (mplier_q[0])
                            acc_q <= alu_rst;
                        mcand_q  <= mcand_q << 1;
                        mplier_q <= mplier_q >> 1;
                    end
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST)
                        state_q <= S_FIX;
                end
                S_FIX: begin
                    result_q <= fix_d;
                    state_q  <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready)
                        state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q == S_CALC) || (state_q == S_FIX);
    assign result    = result_q;

    assign alu_op1     = (state_q != S_CALC) ? '0 :
                         is_div_q ? {acc_q[XLEN-2:0], mplier_q[XLEN-1]} : acc_q;
    assign alu_op2     = (state_q == S_CALC) ? mcand_q : '0;
    assign alu_add     = (state_q == S_CALC) && is_div_q;
    assign alu_op_type = 3'b000;
    assign alu_shamt   = 6'd0;
    assign alu_shtype  = 1'b0;

endmodule

// File: tb/tb_mdu_seq.sv
// tb/tb_mdu_seq.sv - directed vector bench for mdu_seq with a behavioural ALU
module tb_mdu_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready, busy;
    logic [2:0]  func;
    logic [63:0] src1, src2, result;
    logic [63:0] alu_op1, alu_op2, alu_rst;
    logic [2:0]  alu_op_type;
    logic        alu_add, alu_shtype, alu_lt;
    logic [5:0]  alu_shamt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Shared ALU: add/subtract plus unsigned less-than.
    assign alu_rst = alu_add ? (alu_op1 - alu_op2) : (alu_op1 + alu_op2);
    assign alu_lt  = alu_op1 < alu_op2;

    mdu_seq #(.XLEN(64), .CNT_W(6)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .func(func), .src1(src1), .src2(src2),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .busy(busy),
        .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_op_type(alu_op_type),
        .alu_add(alu_add), .alu_shamt(alu_shamt), .alu_shtype(alu_shtype),
        .alu_rst(alu_rst), .alu_lt(alu_lt)
    );

    typedef struct {
        logic [2:0]  f;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one request and wait for out_valid. lat counts the accept edge as
    // cycle 0, so a result visible right after the accept edge has lat=1.
    task automatic run_op(input logic [2:0] f, input logic [63:0] a, input logic [63:0] b,
                          input logic ordy, output logic [63:0] res, output int lat,
                          output logic sb, output logic sir, output logic sadd);
        @(negedge clk);
        func = f; src1 = a; src2 = b; in_valid = 1'b1; out_ready = ordy;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1; sb = 1'b0; sir = 1'b0; sadd = 1'b0;
        while (!out_valid && lat < 200) begin
            sb   |= busy;
            sir  |= in_ready;
            sadd |= alu_add;
            @(posedge clk);
            #1;
            lat++;
        end
        res = result;
        if (ordy) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [63:0] res;
        int          lat;
        logic        sb, sir, sadd;
        logic        hold_ok;

        vecs[0]  = '{3'b000, 64'd7, 64'd6, 64'd42, 66};
        vecs[1]  = '{3'b000, 64'd3, 64'd5, 64'd15, 66};
        vecs[2]  = '{3'b000, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7, 64'hFFFF_FFFF_FFFF_FFEB, 66};
        vecs[3]  = '{3'b000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 66};
        vecs[4]  = '{3'b010, 64'd6, 64'd7, 64'd42, 66};
        vecs[5]  = '{3'b100, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 66};
        vecs[6]  = '{3'b110, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66};
        vecs[7]  = '{3'b100, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 66};
        vecs[8]  = '{3'b110, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 66};
        vecs[9]  = '{3'b101, 64'd100, 64'd7, 64'd14, 66};
        vecs[10] = '{3'b111, 64'd100, 64'd7, 64'd2, 66};
        vecs[11] = '{3'b101, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'h5555_5555_5555_5555, 66};
        vecs[12] = '{3'b111, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, 64'h7FFF_FFFF_FFFF_FFFE, 66};
        vecs[13] = '{3'b101, 64'd100, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1};
        vecs[14] = '{3'b111, 64'd100, 64'd0, 64'd100, 1};
        vecs[15] = '{3'b100, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1};
        vecs[16] = '{3'b110, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1};
        vecs[17] = '{3'b110, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 64'hFFFF_FFFF_FFFF_FFFB, 1};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        func = 3'b000; src1 = '0; src2 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready",  {63'd0, in_ready},  64'd1);
        check("reset_out_valid", {63'd0, out_valid}, 64'd0);
        check("reset_busy",      {63'd0, busy},      64'd0);
        check("reset_result",    result,             64'd0);
        check("reset_alu_ops",   alu_op1 | alu_op2 | {63'd0, alu_add}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 18; i++) begin
            run_op(vecs[i].f, vecs[i].a, vecs[i].b, 1'b1, res, lat, sb, sir, sadd);
            check($sformatf("v%0d_result", i), res, vecs[i].exp);
            check($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
            check($sformatf("v%0d_busy_seen", i), {63'd0, sb}, {63'd0, vecs[i].lat != 1});
            check($sformatf("v%0d_in_ready_seen", i), {63'd0, sir}, 64'd0);
            check($sformatf("v%0d_sub_seen", i), {63'd0, sadd},
                  {63'd0, (vecs[i].lat != 1) && vecs[i].f[2]});
            check($sformatf("v%0d_alu_const", i),
                  {55'd0, alu_op_type, alu_shamt}, {63'd0, alu_shtype});
            check($sformatf("v%0d_idle_after", i), {63'd0, in_ready}, 64'd1);
        end

        // Back-pressure: result held for 10 cycles with out_ready low.
        run_op(3'b101, 64'd100, 64'd7, 1'b0, res, lat, sb, sir, sadd);
        check("bp_result", res, 64'd14);
        check("bp_latency", 64'(lat), 64'd66);
        hold_ok = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            if (!out_valid || in_ready || result !== 64'd14 || busy) hold_ok = 1'b0;
        end
        check("bp_hold_stable", {63'd0, hold_ok}, 64'd1);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_out_valid", {63'd0, out_valid}, 64'd0);
        check("bp_release_in_ready",  {63'd0, in_ready},  64'd1);

        // Reset in the middle of CALC, then a fresh multiply.
        @(negedge clk);
        func = 3'b000; src1 = 64'd3; src2 = 64'd5; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        check("mid_busy_before_reset", {63'd0, busy}, 64'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_in_ready",  {63'd0, in_ready},  64'd1);
        check("rst_mid_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_mid_busy",      {63'd0, busy},      64'd0);
        check("rst_mid_alu_ops",   alu_op1 | alu_op2 | {63'd0, alu_add}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op(3'b000, 64'd3, 64'd5, 1'b1, res, lat, sb, sir, sadd);
        check("post_rst_mul_result", res, 64'd15);
        check("post_rst_mul_latency", 64'(lat), 64'd66);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
